// File: rtl/safecrack_pkg.sv
// rtl/safecrack_pkg.sv - shared button code type, idle code and encoder state encoding
package safecrack_pkg;

  typedef logic [3:0] btn_t;

  localparam btn_t BTN_NONE = 4'b1111;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    DEBOUNCE = 5'b00010,
    EMIT     = 5'b00100,
    HELD     = 5'b01000,
    REL_DB   = 5'b10000
  } enc_state_t;

  // A legal press code has exactly one button pulled low.
  function automatic logic is_one_cold(input btn_t b);
    btn_t inv;
    inv = ~b;
    return ($countones(inv) == 1);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - parameterised-width 2-FF synchroniser, resets to all-ones (buttons released)
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_press_encoder.sv
// rtl/btn_press_encoder.sv - debounced single-button press encoder for the safecrack lock FSM
// Optional BTN_ENC_MULTI_ERR_EN: strobe multi_err on a debounced multi-button press.
module btn_press_encoder
  import safecrack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_o,
  output logic       press_valid,
  output logic       busy,
  output logic [7:0] press_cnt,
  output logic       multi_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  btn_t             s;
  btn_t             cand, cand_nxt;
  enc_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       press_cnt_r;

  btn_sync #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= BTN_NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // The counter stops at CNT_LAST: the qualifying edge changes state instead of counting.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    case (state)
      IDLE: begin
        if (s != BTN_NONE) begin
          cand_nxt  = s;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s != cand) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = is_one_cold(cand) ? EMIT : HELD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      EMIT: begin
        state_nxt = HELD;
      end
      HELD: begin
        if (s == BTN_NONE) begin
          cnt_nxt   = '0;
          state_nxt = REL_DB;
        end
      end
      REL_DB: begin
        if (s != BTN_NONE) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt_r <= 8'h00;
    end else if (state == EMIT) begin
      press_cnt_r <= press_cnt_r + 8'h01;
    end
  end

`ifdef BTN_ENC_MULTI_ERR_EN
  logic multi_err_r;

  // DEBOUNCE only ever goes to HELD when the debounced code had several buttons low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_err_r <= 1'b0;
    end else begin
      multi_err_r <= (state == DEBOUNCE) && (state_nxt == HELD);
    end
  end

  assign multi_err = multi_err_r;
`else
  assign multi_err = 1'b0;
`endif

  assign btn_o       = (state == EMIT) ? cand : BTN_NONE;
  assign press_valid = (state == EMIT);
  assign busy        = (state != IDLE);
  assign press_cnt   = press_cnt_r;

endmodule

// File: tb/tb_btn_press_encoder.sv
// tb/tb_btn_press_encoder.sv - self-checking bench for btn_press_encoder with DEBOUNCE_CYCLES=4
module tb_btn_press_encoder;

  localparam int D = 4;

  localparam int P_IDLE  = 0;
  localparam int P_QUAL  = 1;
  localparam int P_PULSE = 2;
  localparam int P_WAIT  = 3;
  localparam int P_RELQ  = 4;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] cand;
    int         ph;
    int         rem;
    logic [7:0] cnt;
    logic       multi;
  } mdl_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_o;
  logic       press_valid;
  logic       busy;
  logic [7:0] press_cnt;
  logic       multi_err;

  int total;
  int passed;
  int edge_n;
  int pulses;
  int multis;
  int last_edge;
  logic [3:0] last_btn;

  mdl_t m;

  btn_press_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_o       (btn_o),
    .press_valid (press_valid),
    .busy        (busy),
    .press_cnt   (press_cnt),
    .multi_err   (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int zeros(input logic [3:0] b);
    int z;
    z = 0;
    for (int i = 0; i < 4; i++) if (!b[i]) z++;
    return z;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.s1 = 4'hF; r.s2 = 4'hF; r.cand = 4'hF;
    r.ph = P_IDLE; r.rem = 0; r.cnt = 8'h00; r.multi = 1'b0;
    return r;
  endfunction

  // Press phases with a remaining-cycles countdown; s is raw input delayed two edges.
  function automatic mdl_t mdl_next(input mdl_t cur, input logic [3:0] raw);
    mdl_t n;
    logic [3:0] s;
    n = cur;
    s = cur.s2;
    n.s1 = raw;
    n.s2 = cur.s1;
    n.multi = 1'b0;
    case (cur.ph)
      P_IDLE: if (s != 4'hF) begin n.cand = s; n.rem = D; n.ph = P_QUAL; end
      P_QUAL: begin
        if (s != cur.cand) n.ph = P_IDLE;
        else begin
          n.rem = cur.rem - 1;
          if (n.rem == 0) begin
            if (zeros(cur.cand) == 1) n.ph = P_PULSE;
            else begin n.ph = P_WAIT; n.multi = 1'b1; end
          end
        end
      end
      P_PULSE: begin n.cnt = cur.cnt + 8'h01; n.ph = P_WAIT; end
      P_WAIT: if (s == 4'hF) begin n.rem = D; n.ph = P_RELQ; end
      P_RELQ: begin
        if (s != 4'hF) n.ph = P_WAIT;
        else begin
          n.rem = cur.rem - 1;
          if (n.rem == 0) n.ph = P_IDLE;
        end
      end
      default: n.ph = P_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= mdl_next(m, btn_raw);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    logic [14:0] exp_v;
    logic        exp_multi;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
`ifdef BTN_ENC_MULTI_ERR_EN
    exp_multi = m.multi;
`else
    exp_multi = 1'b0;
`endif
    exp_v = {(m.ph == P_PULSE) ? m.cand : 4'hF, m.ph == P_PULSE, m.ph != P_IDLE, m.cnt, exp_multi};
    check("cycle {btn_o,valid,busy,press_cnt,multi_err}",
          {17'd0, btn_o, press_valid, busy, press_cnt, multi_err}, {17'd0, exp_v});
    if (press_valid === 1'b1) begin
      pulses++;
      last_btn  = btn_o;
      last_edge = edge_n;
    end
    if (multi_err === 1'b1) multis++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total = 0; passed = 0; edge_n = 0; pulses = 0; multis = 0;
    last_edge = 0; last_btn = 4'hF;
    rst_n = 1'b0;
    btn_raw = 4'hF;
    ticks(3);
    rst_n = 1'b1;

    // 1: idle after reset
    ticks(20);
    check("idle btn_o", btn_o, 4'hF);
    check("idle busy", busy, 0);
    check("idle press_cnt", press_cnt, 0);
    check("idle pulses", pulses, 0);

    // 2: clean press of 4'b1110
    pulses = 0; edge_n = 0;
    btn_raw = 4'b1110;
    ticks(30);
    check("press1 pulses", pulses, 1);
    check("press1 pulse edge", last_edge, D + 3);
    check("press1 code", last_btn, 4'b1110);
    check("press1 press_cnt", press_cnt, 1);
    btn_raw = 4'hF;
    ticks(10);
    check("press1 busy after release", busy, 0);

    // 3: bouncing 4'b1101 then stable
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      btn_raw = 4'b1101; ticks(2);
      btn_raw = 4'hF;    ticks(2);
    end
    check("bounce pulses", pulses, 0);
    btn_raw = 4'b1101;
    ticks(20);
    check("bounce settled pulses", pulses, 1);
    check("bounce settled code", last_btn, 4'b1101);
    check("bounce press_cnt", press_cnt, 2);
    btn_raw = 4'hF;
    ticks(10);

    // 4: multi-button press
    pulses = 0; multis = 0;
    btn_raw = 4'b1100;
    ticks(30);
    check("multi pulses", pulses, 0);
    check("multi press_cnt", press_cnt, 2);
`ifdef BTN_ENC_MULTI_ERR_EN
    check("multi_err pulses", multis, 1);
`else
    check("multi_err pulses", multis, 0);
`endif
    btn_raw = 4'hF;
    ticks(10);
    check("multi busy after release", busy, 0);

    // 5: 256 presses wrap press_cnt, then a long hold
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      btn_raw = 4'b0111; ticks(12);
      btn_raw = 4'hF;    ticks(12);
    end
    check("wrap pulses", pulses, 256);
    check("wrap press_cnt", press_cnt, 0);
    check("wrap code", last_btn, 4'b0111);
    pulses = 0;
    btn_raw = 4'b0111;
    ticks(100);
    check("long hold pulses", pulses, 1);
    check("long hold press_cnt", press_cnt, 1);
    btn_raw = 4'hF;
    ticks(10);

    // 6: reset during debounce
    pulses = 0;
    btn_raw = 4'b1011;
    ticks(4);
    check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async reset btn_o", btn_o, 4'hF);
    check("async reset valid", press_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset press_cnt", press_cnt, 0);
    btn_raw = 4'hF;
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    check("post-reset pulses", pulses, 0);
    btn_raw = 4'b1011;
    ticks(20);
    check("re-press pulses", pulses, 1);
    check("re-press code", last_btn, 4'b1011);
    check("re-press press_cnt", press_cnt, 1);
    btn_raw = 4'hF;
    ticks(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
